// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC select encodings
// and the default address width.
package pc_seq_pkg;

    localparam int ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        MODE_INC = 2'b00,
        MODE_REL = 2'b01,
        MODE_ABS = 2'b10,
        MODE_RET = 2'b11
    } mode_e;

endpackage

// File: rtl/pc_seq_ras.sv
// Circular return-address stack. When it is full, a push overwrites the oldest entry.
// A pop on an empty stack leaves the stack unchanged.
module pc_ras #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         ovf,
    output logic         unf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] tp_q, tp_d;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];

    assign wr_ptr = tp_q + 1'b1;
    assign empty  = (count_q == CW'(0));
    assign full   = (count_q == CW'(DEPTH));
    assign ovf    = push & full;
    assign unf    = pop & empty;
    assign dout   = mem_q[tp_q];

    always_comb begin
        tp_d    = tp_q;
        count_d = count_q;
        if (push) begin
            tp_d = wr_ptr;
            if (!full) begin
                count_d = count_q + 1'b1;
            end
        end else if (pop && !empty) begin
            tp_d    = tp_q - 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tp_q    <= '0;
            count_q <= '0;
        end else begin
            tp_q    <= tp_d;
            count_q <= count_d;
        end
    end

    // Entries need no reset: the stack is never read while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/pc_seq_unit.sv
// Registered program-counter sequencer. It selects increment, relative branch, absolute jump
// or return, and keeps call return addresses on an internal circular stack.
module pc_seq_unit
    import pc_seq_pkg::*;
#(
    parameter int               ADDR_W    = ADDR_W_DEF,
    parameter int               RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              call,
    input  logic [ADDR_W-1:0] imm,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] pc,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_err
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_push, ras_pop, ras_ovf, ras_unf;

    assign pc_inc = pc_q + 1'b1;

    // A push is possible only with REL or ABS, so a push and a pop never happen together.
    assign ras_push = en & call & ((mode == MODE_REL) | (mode == MODE_ABS));
    assign ras_pop  = en & (mode == MODE_RET);

    pc_ras #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_inc),
        .dout  (ras_top),
        .empty (ras_empty),
        .full  (ras_full),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

    always_comb begin
        pc_d = pc_q;
        if (en) begin
            unique case (mode)
                MODE_INC: pc_d = pc_inc;
                MODE_REL: pc_d = pc_q + imm;
                MODE_ABS: pc_d = imm;
                MODE_RET: pc_d = ras_empty ? pc_inc : ras_top;
                default:  pc_d = pc_inc;
            endcase
        end
    end

    // If an error occurs in the same cycle as a clear, the error takes priority.
    always_comb begin
        err_d = err_q;
        if (ras_ovf || ras_unf) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VEC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign pc      = pc_q;
    assign ras_err = err_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: a queue-based reference model is checked on every falling edge,
// followed by directed scenarios with literal expectations and randomized traffic.
module tb_pc_seq_unit;

    localparam int          AW    = 16;
    localparam int          DEPTH = 4;
    localparam logic [AW-1:0] RV  = 16'h0000;

    localparam logic [1:0] INC = 2'b00;
    localparam logic [1:0] REL = 2'b01;
    localparam logic [1:0] ABS = 2'b10;
    localparam logic [1:0] RET = 2'b11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          call = 1'b0;
    logic [AW-1:0] imm = '0;
    logic          err_clr = 1'b0;
    logic [AW-1:0] pc;
    logic          ras_empty, ras_full, ras_err;

    int vectors = 0;
    int miscompares = 0;

    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stk[$];
    logic          m_err;

    pc_seq_unit #(
        .ADDR_W    (AW),
        .RAS_DEPTH (DEPTH),
        .RESET_VEC (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .call      (call),
        .imm       (imm),
        .err_clr   (err_clr),
        .pc        (pc),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_err   (ras_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RV;
        m_stk.delete();
        m_err = 1'b0;
    endtask

    // The stack is modelled as a bounded list: the newest entry is at the back,
    // and the oldest entry is dropped from the front when the list overflows.
    task automatic model_step();
        logic          set_err;
        logic [AW-1:0] nxt;
        set_err = 1'b0;
        nxt     = m_pc;
        if (en) begin
            case (mode)
                INC: nxt = AW'(m_pc + 1);
                REL: nxt = AW'(m_pc + imm);
                ABS: nxt = imm;
                default: begin
                    if (m_stk.size() == 0) begin
                        nxt     = AW'(m_pc + 1);
                        set_err = 1'b1;
                    end else begin
                        nxt = m_stk.pop_back();
                    end
                end
            endcase
            if (call && (mode == REL || mode == ABS)) begin
                if (m_stk.size() == DEPTH) begin
                    void'(m_stk.pop_front());
                    set_err = 1'b1;
                end
                m_stk.push_back(AW'(m_pc + 1));
            end
            m_pc = nxt;
        end
        if (set_err) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
    endtask

    always @(negedge clk) begin
        chk("pc", pc, m_pc);
        chk("ras_empty", AW'(ras_empty), AW'(m_stk.size() == 0));
        chk("ras_full", AW'(ras_full), AW'(m_stk.size() == DEPTH));
        chk("ras_err", AW'(ras_err), AW'(m_err));
    end

    task automatic step(input logic e, input logic [1:0] m, input logic c,
                        input logic [AW-1:0] i, input logic clr);
        en      = e;
        mode    = m;
        call    = c;
        imm     = i;
        err_clr = clr;
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
    endtask

    // Reset is asserted between edges, and its effect is checked before the next clock edge.
    task automatic async_reset(input logic lit);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        if (lit) begin
            chk("async_pc", pc, RV);
            chk("async_empty", AW'(ras_empty), AW'(1));
            chk("async_err", AW'(ras_err), AW'(0));
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_pc", pc, 16'h0000);
        chk("reset_empty", AW'(ras_empty), AW'(1));
        chk("reset_full", AW'(ras_full), AW'(0));

        // Assert reset mid-run, then increment and stall.
        step(1, ABS, 1, 16'h0040, 0);
        step(1, INC, 0, 16'h0000, 0);
        async_reset(1);
        for (int k = 1; k <= 4; k++) begin
            step(1, INC, 0, 16'h0000, 0);
            chk("inc_pc", pc, AW'(k));
        end
        step(0, INC, 0, 16'h0000, 0);
        step(0, ABS, 1, 16'h1234, 0);
        chk("stall_pc", pc, 16'h0004);
        chk("stall_empty", AW'(ras_empty), AW'(1));

        // Relative branches that wrap around the address space.
        step(1, ABS, 0, 16'hFFFE, 0);
        step(1, REL, 0, 16'h0003, 0);
        chk("rel_wrap_fwd", pc, 16'h0001);
        step(1, REL, 0, 16'hFFFE, 0);
        chk("rel_wrap_back", pc, 16'hFFFF);

        // Nested calls and returns.
        step(1, ABS, 0, 16'h0010, 0);
        step(1, ABS, 1, 16'h0100, 0);
        chk("call1_pc", pc, 16'h0100);
        chk("call1_empty", AW'(ras_empty), AW'(0));
        step(1, REL, 1, 16'h0020, 0);
        chk("call2_pc", pc, 16'h0120);
        step(1, RET, 0, 16'h0000, 0);
        chk("ret1_pc", pc, 16'h0101);
        step(1, RET, 0, 16'h0000, 0);
        chk("ret2_pc", pc, 16'h0011);
        chk("ret2_empty", AW'(ras_empty), AW'(1));
        chk("ret2_err", AW'(ras_err), AW'(0));

        // Overflow: the return address 0x01 from the first call is overwritten.
        step(1, ABS, 0, 16'h0000, 0);
        for (int k = 1; k <= 5; k++) step(1, ABS, 1, AW'(k * 16), 0);
        chk("ovf_full", AW'(ras_full), AW'(1));
        chk("ovf_err", AW'(ras_err), AW'(1));
        step(1, RET, 0, 16'h0000, 0);
        chk("ovf_ret1", pc, 16'h0041);
        step(1, RET, 0, 16'h0000, 0);
        chk("ovf_ret2", pc, 16'h0031);
        step(1, RET, 0, 16'h0000, 0);
        chk("ovf_ret3", pc, 16'h0021);
        step(1, RET, 0, 16'h0000, 0);
        chk("ovf_ret4", pc, 16'h0011);
        chk("ovf_empty", AW'(ras_empty), AW'(1));

        // Underflow, clearing the error while stalled, and an error set in the same cycle as a clear.
        step(1, ABS, 0, 16'h0007, 1);
        chk("unf_pre_err", AW'(ras_err), AW'(0));
        step(1, RET, 0, 16'h0000, 0);
        chk("unf_pc", pc, 16'h0008);
        chk("unf_err", AW'(ras_err), AW'(1));
        step(0, RET, 0, 16'h0000, 1);
        chk("clr_err", AW'(ras_err), AW'(0));
        chk("clr_pc_hold", pc, 16'h0008);
        step(1, RET, 0, 16'h0000, 1);
        chk("setwins_err", AW'(ras_err), AW'(1));
        chk("setwins_pc", pc, 16'h0009);

        // A call with INC is ignored; reset is then asserted with three entries on the stack.
        step(1, INC, 0, 16'h0000, 1);
        for (int k = 0; k < 3; k++) step(1, ABS, 1, AW'(16'h0200 + k), 0);
        step(1, INC, 1, 16'h0000, 0);
        chk("ign_pc", pc, 16'h0203);
        chk("ign_full", AW'(ras_full), AW'(0));
        chk("ign_empty", AW'(ras_empty), AW'(0));
        async_reset(1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset(0);
            end else begin
                step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) != 0) ? AW'($urandom) : AW'($urandom_range(0, 8)),
                     $urandom_range(0, 15) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
